// File: rtl/ternary_serial_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tern_pkg
//  Description : Shared definitions for the bit-serial ternary ALU: trit
//                encodings, operation codes and the sequencer state type.
//                Trit encoding {x1,x0}: 0 = 00, 1 = 10, 2 = 01, 11 = illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
package tern_pkg;

   // Trit codes as {x1,x0}
   localparam logic [1:0] T_ZERO = 2'b00;
   localparam logic [1:0] T_ONE  = 2'b10;
   localparam logic [1:0] T_TWO  = 2'b01;
   localparam logic [1:0] T_ILL  = 2'b11;

   // Operation codes
   localparam logic [1:0] OP_MAX  = 2'b00;
   localparam logic [1:0] OP_CONS = 2'b01;
   localparam logic [1:0] OP_MIN  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ternary_serial_alu_trit_op.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_trit_op
//  Description : Combinational single-trit operator. Applies MAX, CONSENSUS
//                or (optionally) MIN to one trit pair. An illegal operand
//                code or an unsupported op yields a zero trit and raises ill.
//  Config      : TERN_MIN_EN - when defined, op 10 performs MIN; otherwise
//                op 10 behaves as a reserved op and no MIN logic exists.
//  Ports       : op        in  2  operation code
//                a0, a1    in  1  operand A trit {a1,a0}
//                b0, b1    in  1  operand B trit {b1,b0}
//                out0,out1 out 1  result trit {out1,out0}
//                ill       out 1  illegal operand or unsupported op
//  Revision    : 1.0 - initial release
// ============================================================================
module ternary_trit_op
   import tern_pkg::*;
(
   input  logic [1:0] op,
   input  logic       a0,
   input  logic       a1,
   input  logic       b0,
   input  logic       b1,
   output logic       out0,
   output logic       out1,
   output logic       ill
);

   logic w_a_ill;
   logic w_b_ill;
   logic w_op_ok;
   logic w_max0;
   logic w_max1;
   logic w_cons0;
   logic w_cons1;

   always_comb begin
      w_a_ill = ({a1, a0} == T_ILL);
      w_b_ill = ({b1, b0} == T_ILL);

      w_max0  = a0 | b0;
      w_max1  = (a1 | b1) & ~w_max0;
      w_cons0 = a0 & b0;
      w_cons1 = a1 | b1 | (a0 ^ b0);

      out0    = 1'b0;
      out1    = 1'b0;
      w_op_ok = 1'b0;
      case (op)
         OP_MAX: begin
            out0    = w_max0;
            out1    = w_max1;
            w_op_ok = 1'b1;
         end
         OP_CONS: begin
            out0    = w_cons0;
            out1    = w_cons1;
            w_op_ok = 1'b1;
         end
`ifdef TERN_MIN_EN
         OP_MIN: begin
            out0    = a0 & b0;
            out1    = (a0 | a1) & (b0 | b1) & ~(a0 & b0);
            w_op_ok = 1'b1;
         end
`endif
         default: begin
            w_op_ok = 1'b0;
         end
      endcase

      ill = w_a_ill | w_b_ill | ~w_op_ok;

      // Any error condition collapses the result trit to zero
      if (ill) begin
         {out1, out0} = T_ZERO;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ternary_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_serial_alu
//  Description : Bit-serial ternary operand sequencer and result collector.
//                Accepts two N-trit words, streams them LSB first through a
//                single trit operator (one trit per cycle), reassembles the
//                result word and offers it on a valid/ready output.
//  Config      : TERN_MIN_EN - enables the MIN operation (op 10) in the
//                trit operator; otherwise op 10 is reserved.
//  Ports       : clk            in  1  clock
//                rst            in  1  synchronous active-high reset
//                in_valid       in  1  operand word offered
//                in_ready       out 1  block idle, can accept operands
//                op             in  2  00 MAX, 01 CONSENSUS, 10 MIN, 11 rsvd
//                a0,a1,b0,b1    in  N  operands, trit i = {x1[i], x0[i]}
//                out_valid      out 1  result word available
//                out_ready      in  1  consumer takes result
//                r0, r1         out N  result word
//                err            out 1  illegal trit or reserved op seen
//  Revision    : 1.0 - initial release
// ============================================================================
module ternary_serial_alu
   import tern_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b0,
   input  logic [N-1:0] b1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] r0,
   output logic [N-1:0] r1,
   output logic         err
);

   localparam int            CW   = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t         state_q,     state_d;
   logic [CW-1:0]  count_q,     count_d;
   logic [1:0]     op_q,        op_d;
   logic [N-1:0]   a0_q,        a0_d;
   logic [N-1:0]   a1_q,        a1_d;
   logic [N-1:0]   b0_q,        b0_d;
   logic [N-1:0]   b1_q,        b1_d;
   logic [N-1:0]   r0_q,        r0_d;
   logic [N-1:0]   r1_q,        r1_d;
   logic           err_q,       err_d;
   logic           out_valid_q, out_valid_d;
   logic           in_ready_q,  in_ready_d;

   logic           w_t0;
   logic           w_t1;
   logic           w_ill;
   logic [N-1:0]   w_r0_ins;
   logic [N-1:0]   w_r1_ins;

   // Operands are shifted right each RUN cycle, so the trit being processed
   // is always at bit 0.
   ternary_trit_op u_trit_op (
      .op   (op_q),
      .a0   (a0_q[0]),
      .a1   (a1_q[0]),
      .b0   (b0_q[0]),
      .b1   (b1_q[0]),
      .out0 (w_t0),
      .out1 (w_t1),
      .ill  (w_ill)
   );

   // Results enter at the MSB and move down; after N insertions trit 0 sits
   // at bit 0.
   generate
      if (N == 1) begin : g_single
         assign w_r0_ins = w_t0;
         assign w_r1_ins = w_t1;
      end else begin : g_multi
         assign w_r0_ins = {w_t0, r0_q[N-1:1]};
         assign w_r1_ins = {w_t1, r1_q[N-1:1]};
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      op_d        = op_q;
      a0_d        = a0_q;
      a1_d        = a1_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      r0_d        = r0_q;
      r1_d        = r1_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d       = op;
               a0_d       = a0;
               a1_d       = a1;
               b0_d       = b0;
               b1_d       = b1;
               r0_d       = '0;
               r1_d       = '0;
               count_d    = '0;
               err_d      = 1'b0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            a0_d    = a0_q >> 1;
            a1_d    = a1_q >> 1;
            b0_d    = b0_q >> 1;
            b1_d    = b1_q >> 1;
            r0_d    = w_r0_ins;
            r1_d    = w_r1_ins;
            err_d   = err_q | w_ill;
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         op_q        <= OP_MAX;
         a0_q        <= '0;
         a1_q        <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         r0_q        <= '0;
         r1_q        <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         op_q        <= op_d;
         a0_q        <= a0_d;
         a1_q        <= a1_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         r0_q        <= r0_d;
         r1_q        <= r1_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign r0        = r0_q;
   assign r1        = r1_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ternary_serial_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ternary_serial_alu
//  Description : Scoreboard bench for ternary_serial_alu with N = 4. The
//                driver pushes hand-computed expected words when an operand
//                word is accepted; a monitor pops and compares them when the
//                DUT presents a result, and also checks latency and hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ternary_serial_alu;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [N-1:0] a0, a1, b0, b1;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] r0, r1;
   logic         err;

   always #5 clk = ~clk;

   ternary_serial_alu #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a0        (a0),
      .a1        (a1),
      .b0        (b0),
      .b1        (b1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r0        (r0),
      .r1        (r1),
      .err       (err)
   );

   typedef struct {
      logic [N-1:0] r0;
      logic [N-1:0] r1;
      logic         err;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compares results on the rising out_valid, then checks hold.
   initial begin : monitor
      logic         prev_ov;
      logic [N-1:0] hold0, hold1;
      logic         hold_e;
      exp_t         cur;
      prev_ov = 1'b0;
      hold0   = '0;
      hold1   = '0;
      hold_e  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ov = 1'b0;
         end else begin
            if (out_valid && !prev_ov) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 32'd1, 32'd0);
               end else begin
                  cur = sb.pop_front();
                  chk("latency", cyc, cur.cyc);
                  chk("r0", r0, cur.r0);
                  chk("r1", r1, cur.r1);
                  chk("err", err, cur.err);
                  hold0  = r0;
                  hold1  = r1;
                  hold_e = err;
               end
            end else if (out_valid) begin
               chk("hold_r0", r0, hold0);
               chk("hold_r1", r1, hold1);
               chk("hold_err", err, hold_e);
            end
            if (out_valid) chk("in_ready_busy", in_ready, 1'b0);
            prev_ov = out_valid && !out_ready;
         end
      end
   end

   task automatic send(input logic [1:0] o,
                       input logic [N-1:0] xa0, input logic [N-1:0] xa1,
                       input logic [N-1:0] xb0, input logic [N-1:0] xb1,
                       input logic [N-1:0] e0, input logic [N-1:0] e1,
                       input logic ee, input bit push);
      exp_t e;
      int   waited;
      waited = 0;
      @(negedge clk);
      op = o; a0 = xa0; a1 = xa1; b0 = xb0; b1 = xb1;
      in_valid = 1'b1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd1, 32'd0);
         in_valid = 1'b0;
         return;
      end
      e.r0  = e0;
      e.r1  = e1;
      e.err = ee;
      e.cyc = cyc + 1 + N;
      if (push) sb.push_back(e);
      @(negedge clk);
      // Scramble operands after accept; they must not influence the word
      in_valid = 1'b0;
      op = 2'($urandom);
      a0 = N'($urandom); a1 = N'($urandom);
      b0 = N'($urandom); b1 = N'($urandom);
   endtask

   task automatic wait_idle();
      int waited;
      waited = 0;
      while ((sb.size() != 0 || out_valid) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0 || out_valid) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin : main
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 2'b00;
      a0 = '0; a1 = '0; b0 = '0; b1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_r0", r0, 4'b0000);
      chk("rst_r1", r1, 4'b0000);
      chk("rst_err", err, 1'b0);

      // A = [2,1,0,2], B = [0,1,2,1] (MSB first)
      send(2'b00, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b1011, 4'b0100, 1'b0, 1);
      send(2'b01, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b0000, 4'b1111, 1'b0, 1);
`ifdef TERN_MIN_EN
      send(2'b10, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b0000, 4'b0101, 1'b0, 1);
`else
      send(2'b10, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b0000, 4'b0000, 1'b1, 1);
`endif
      send(2'b11, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b0000, 4'b0000, 1'b1, 1);
      // A trit1 illegal
      send(2'b00, 4'b1011, 4'b0110, 4'b0010, 4'b0101, 4'b1001, 4'b0100, 1'b1, 1);
      // Clean word clears err
      send(2'b00, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b1011, 4'b0100, 1'b0, 1);
      // B trit0 illegal
      send(2'b00, 4'b1001, 4'b0100, 4'b0011, 4'b0101, 4'b1010, 4'b0100, 1'b1, 1);
      // All 2s vs all 1s
      send(2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1);
      send(2'b01, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b0, 1);
      wait_idle();

      // Back-pressure: result held, new operands refused
      out_ready = 1'b0;
      send(2'b01, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b0000, 4'b1111, 1'b0, 1);
      begin
         int waited;
         waited = 0;
         while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         if (!out_valid) chk("stall_valid_timeout", 32'd1, 32'd0);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op = 2'b00; a0 = 4'b1111; a1 = 4'b0000; b0 = 4'b0000; b1 = 4'b0000;
         chk("stall_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Reset while RUN with count = 2: word is dropped
      send(2'b00, 4'b1001, 4'b0100, 4'b0010, 4'b0101, 4'b1011, 4'b0100, 1'b0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_r0", r0, 4'b0000);
      chk("midrst_r1", r1, 4'b0000);
      chk("midrst_err", err, 1'b0);
      repeat (N + 3) @(negedge clk);
      chk("midrst_no_valid", out_valid, 1'b0);

      // Word after reset completes normally
      send(2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
